// File: rtl/shift_pkg.sv
// Shared types for the pipelined shifter: operation encoding and per-stage control payload.
package shift_pkg;

    typedef enum logic [2:0] {
        SHIFT_SLL = 3'd0,
        SHIFT_SRL = 3'd1,
        SHIFT_SRA = 3'd2,
        SHIFT_ROL = 3'd3,
        SHIFT_ROR = 3'd4
    } shift_op_t;

    // Control part of a stage payload; the WIDTH-dependent data word travels beside it.
    typedef struct packed {
        logic      valid;
        shift_op_t op;
        logic      carry;
    } shift_ctl_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel stage: shift by DIST when en is set, otherwise pass through.
// Rotate modes exist only when SHIFT_UNIT_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic             en,
    input  shift_op_t        op,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    // Mode-dependent fill; reserved ops leave the word untouched
    always_comb begin
        y = a;
        if (en) begin
            case (op)
                SHIFT_SLL: y = a << DIST;
                SHIFT_SRL: y = a >> DIST;
                SHIFT_SRA: y = WIDTH'($signed(a) >>> DIST);
`ifdef SHIFT_UNIT_ROTATE_EN
                SHIFT_ROL: y = {a[WIDTH-DIST-1:0], a[WIDTH-1:WIDTH-DIST]};
                SHIFT_ROR: y = {a[DIST-1:0], a[WIDTH-1:DIST]};
`endif
                default:   y = a;
            endcase
        end else begin
            y = a;
        end
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined log2(WIDTH)-stage shifter with valid/ready on both sides and carry/zero flags.
// Optional rotate support is enabled by defining SHIFT_UNIT_ROTATE_EN.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   in_shamt,
    input  shift_op_t        in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_carry,
    output logic             out_zero
);

    localparam int MID = (SHW > 1) ? SHW - 1 : 1;

    logic             advance_s;
    logic             carry_s;
    logic [SHW-1:0]   sll_idx_s;
    logic [SHW-1:0]   srl_idx_s;

    shift_ctl_t       st_ctl_s   [SHW];
    logic [WIDTH-1:0] st_data_s  [SHW];
    logic [SHW-1:0]   st_shamt_s [SHW];
    logic [WIDTH-1:0] st_y_s     [SHW];

    shift_ctl_t       ctl_r      [MID];
    logic [WIDTH-1:0] data_r     [MID];
    logic [SHW-1:0]   shamt_r    [MID];

    logic             out_valid_r;
    logic             out_carry_r;
    logic             out_zero_r;
    logic [WIDTH-1:0] out_y_r;

    assign advance_s = !out_valid_r || out_ready;
    assign in_ready  = advance_s;

    // WIDTH - shamt, taken modulo WIDTH by the index width
    assign sll_idx_s = {SHW{1'b0}} - in_shamt;
    assign srl_idx_s = in_shamt - SHW'(1'b1);

    // Carry comes from the operand at the input so it can ride the pipe with the data
    always_comb begin
        carry_s = 1'b0;
        if (in_shamt != {SHW{1'b0}}) begin
            case (in_op)
                SHIFT_SLL:            carry_s = in_a[sll_idx_s];
                SHIFT_SRL, SHIFT_SRA: carry_s = in_a[srl_idx_s];
`ifdef SHIFT_UNIT_ROTATE_EN
                SHIFT_ROL:            carry_s = in_a[sll_idx_s];
                SHIFT_ROR:            carry_s = in_a[srl_idx_s];
`endif
                default:              carry_s = 1'b0;
            endcase
        end else begin
            carry_s = 1'b0;
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign st_ctl_s[k]   = '{valid: in_valid, op: in_op, carry: carry_s};
            assign st_data_s[k]  = in_a;
            assign st_shamt_s[k] = in_shamt;
        end else begin : g_link
            assign st_ctl_s[k]   = ctl_r[k-1];
            assign st_data_s[k]  = data_r[k-1];
            assign st_shamt_s[k] = shamt_r[k-1];
        end

        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .en (st_shamt_s[k][k]),
            .op (st_ctl_s[k].op),
            .a  (st_data_s[k]),
            .y  (st_y_s[k])
        );

        if (k < SHW - 1) begin : g_mid
            // Intermediate stage register; holds whenever the pipe is stalled
            always_ff @(posedge clk) begin
                if (rst) begin
                    ctl_r[k]   <= '{valid: 1'b0, op: SHIFT_SLL, carry: 1'b0};
                    data_r[k]  <= {WIDTH{1'b0}};
                    shamt_r[k] <= {SHW{1'b0}};
                end else if (advance_s) begin
                    ctl_r[k]   <= st_ctl_s[k];
                    data_r[k]  <= st_y_s[k];
                    shamt_r[k] <= st_shamt_s[k];
                end
            end
        end
    end

    // Output register: result and both flags are captured together from the last stage
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_carry_r <= 1'b0;
            out_zero_r  <= 1'b0;
            out_y_r     <= {WIDTH{1'b0}};
        end else if (advance_s) begin
            out_valid_r <= st_ctl_s[SHW-1].valid;
            out_carry_r <= st_ctl_s[SHW-1].carry;
            out_zero_r  <= (st_y_s[SHW-1] == {WIDTH{1'b0}});
            out_y_r     <= st_y_s[SHW-1];
        end
    end

    assign out_valid = out_valid_r;
    assign out_carry = out_carry_r;
    assign out_zero  = out_zero_r;
    assign out_y     = out_y_r;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe (WIDTH=8); rotate expectations follow SHIFT_UNIT_ROTATE_EN.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [2:0] in_shamt;
    shift_op_t  in_op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_carry;
    logic       out_zero;

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       z;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   passed  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    int   lat;

    shift_unit_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    function automatic exp_t mk(input logic [7:0] y, input logic c, input logic z);
        exp_t e;
        e.y = y; e.c = c; e.z = z;
        return e;
    endfunction

    // Bit-by-bit reference model, independent of the staged structure
    function automatic exp_t model(input logic [7:0] a, input logic [2:0] s, input shift_op_t op);
        exp_t e;
        int si;
        si  = int'(s);
        e.y = a;
        e.c = 1'b0;
        case (op)
            SHIFT_SLL: begin
                for (int i = 0; i < 8; i++) begin
                    if (i >= si) e.y[i] = a[i-si];
                    else         e.y[i] = 1'b0;
                end
                if (si != 0) e.c = a[8-si];
            end
            SHIFT_SRL, SHIFT_SRA: begin
                for (int i = 0; i < 8; i++) begin
                    if (i + si < 8)          e.y[i] = a[i+si];
                    else if (op == SHIFT_SRA) e.y[i] = a[7];
                    else                     e.y[i] = 1'b0;
                end
                if (si != 0) e.c = a[si-1];
            end
`ifdef SHIFT_UNIT_ROTATE_EN
            SHIFT_ROL: begin
                for (int i = 0; i < 8; i++) e.y[i] = a[(i - si + 8) % 8];
                if (si != 0) e.c = e.y[0];
            end
            SHIFT_ROR: begin
                for (int i = 0; i < 8; i++) e.y[i] = a[(i + si) % 8];
                if (si != 0) e.c = e.y[7];
            end
`endif
            default: e.y = a;
        endcase
        e.z = (e.y == 8'h00);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input logic [7:0] a, input logic [2:0] s, input shift_op_t op, input exp_t e);
        int   n;
        logic rdy;
        in_valid = 1'b1; in_a = a; in_shamt = s; in_op = op;
        n = 0;
        do begin
            @(negedge clk);
            rdy     = in_ready;
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 200);
        check("accept", rdy, 1'b1);
        if (rdy) exp_q.push_back(e);
        in_valid = 1'b0;
    endtask

    task automatic send_m(input logic [7:0] a, input logic [2:0] s, input shift_op_t op);
        send(a, s, op, model(a, s, op));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic measure_latency(input string tag);
        int got;
        got = 0;
        lat = -1;
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1;
                lat = cyc - acc_cyc;
            end
        end
        check(tag, lat, 3);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, exp_q.size(), 0);
    endtask

    exp_t hold;
    exp_t got_e;
    logic stalled = 1'b0;

    // Output monitor: scoreboard pops on handshake, stability checks while stalled
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_y", out_y, hold.y);
                check("stall_carry", out_carry, hold.c);
                check("stall_zero", out_zero, hold.z);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 1'b0);
                hold.y = out_y; hold.c = out_carry; hold.z = out_zero;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                check("out_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    got_e = exp_q.pop_front();
                    check("out_y", out_y, got_e.y);
                    check("out_carry", out_carry, got_e.c);
                    check("out_zero", out_zero, got_e.z);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 8'h00; in_shamt = 3'd0; in_op = SHIFT_SLL; out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_y", out_y, 8'h00);
        check("rst_out_carry", out_carry, 1'b0);
        check("rst_out_zero", out_zero, 1'b0);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);

        send(8'h96, 3'd3, SHIFT_SLL, mk(8'hB0, 1'b0, 1'b0));
        measure_latency("latency_sll");
        drain("drain_first");

        send(8'h96, 3'd2, SHIFT_SRA, mk(8'hE5, 1'b1, 1'b0));
        send(8'h96, 3'd2, SHIFT_SRL, mk(8'h25, 1'b1, 1'b0));
        send(8'h01, 3'd1, SHIFT_SRL, mk(8'h00, 1'b1, 1'b1));
        send(8'h5A, 3'd0, SHIFT_SLL, mk(8'h5A, 1'b0, 1'b0));
        send(8'hA5, 3'd0, SHIFT_SRL, mk(8'hA5, 1'b0, 1'b0));
        send(8'h80, 3'd0, SHIFT_SRA, mk(8'h80, 1'b0, 1'b0));
        send(8'h00, 3'd0, SHIFT_ROL, mk(8'h00, 1'b0, 1'b1));
        send(8'hC3, 3'd0, SHIFT_ROR, mk(8'hC3, 1'b0, 1'b0));
        send(8'h80, 3'd7, SHIFT_SRA, mk(8'hFF, 1'b0, 1'b0));
        send(8'h81, 3'd7, SHIFT_SLL, mk(8'h80, 1'b0, 1'b0));
        send(8'h3C, 3'd3, shift_op_t'(3'd5), mk(8'h3C, 1'b0, 1'b0));
`ifdef SHIFT_UNIT_ROTATE_EN
        send(8'h81, 3'd1, SHIFT_ROR, mk(8'hC0, 1'b1, 1'b0));
        send(8'h81, 3'd1, SHIFT_ROL, mk(8'h03, 1'b1, 1'b0));
`else
        send(8'h81, 3'd1, SHIFT_ROL, mk(8'h81, 1'b0, 1'b0));
        send(8'h81, 3'd1, SHIFT_ROR, mk(8'h81, 1'b0, 1'b0));
`endif
        drain("drain_directed");

        fork
            begin
                send_m(8'h11, 3'd1, SHIFT_SLL);
                send_m(8'hF0, 3'd4, SHIFT_SRA);
                send_m(8'h0F, 3'd2, SHIFT_SRL);
                send_m(8'h96, 3'd5, SHIFT_ROL);
                send_m(8'h69, 3'd6, SHIFT_ROR);
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("drain_backpressure");

        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    if (gap > 0) idle(gap);
                    send_m(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
                           shift_op_t'(3'($urandom_range(0, 7))));
                end
            end
            begin
                repeat (150) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        out_ready = 1'b0;
        send(8'h12, 3'd1, SHIFT_SLL, mk(8'h24, 1'b0, 1'b0));
        send(8'h34, 3'd2, SHIFT_SRL, mk(8'h0D, 1'b0, 1'b0));
        send(8'h56, 3'd3, SHIFT_SRA, mk(8'h0A, 1'b1, 1'b0));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_flush_valid", out_valid, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        idle(6);
        check("post_rst_quiet", out_valid, 1'b0);
        send(8'h01, 3'd1, SHIFT_SRL, mk(8'h00, 1'b1, 1'b1));
        measure_latency("latency_after_rst");
        drain("drain_final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
